// File: rtl/mux_nx1_scan_if.sv
// Channel bus for mux_nx1_scan: N*W input lanes plus control, tagged registered output.
interface mux_nx1_scan_if #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 1
);
   localparam int unsigned SELW = $clog2(N);

   logic [N*W-1:0]  in_bus;
   logic            mode;
   logic [SELW-1:0] sel;
   logic            hold;
   logic [W-1:0]    out;
   logic [SELW-1:0] out_ch;
   logic            out_valid;
   logic            wrap;

   modport master (
      output in_bus, mode, sel, hold,
      input  out, out_ch, out_valid, wrap
   );

   modport slave (
      input  in_bus, mode, sel, hold,
      output out, out_ch, out_valid, wrap
   );
endinterface

// File: rtl/mux_nx1_scan.sv
// N-channel W-bit registered multiplexer with MANUAL select and round-robin SCAN modes.
// Output is tagged with the source channel index, a valid flag and a wrap pulse.
module mux_nx1_scan #(
   parameter int unsigned N     = 4,
   parameter int unsigned W     = 1,
   parameter int unsigned DWELL = 4
) (
   input logic           clk,
   input logic           rst_n,
   mux_nx1_scan_if.slave bus
);
   localparam int unsigned SELW = $clog2(N);
   localparam logic [SELW-1:0] LAST_CH    = SELW'(N - 1);
   localparam logic [7:0]      DWELL_LAST = 8'(DWELL - 1);

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_SCAN   = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [SELW-1:0] ch_q, ch_d;
   logic [7:0]      dwell_q, dwell_d;
   logic [W-1:0]    out_q, out_d;
   logic [SELW-1:0] out_ch_q, out_ch_d;
   logic            valid_q, valid_d;
   logic            wrap_q, wrap_d;

   logic [W-1:0]    chan [N];
   logic            sel_ok;

   for (genvar k = 0; k < int'(N); k++) begin : g_chan
      assign chan[k] = bus.in_bus[k*W +: W];
   end

   function automatic logic [W-1:0] pick(input logic [SELW-1:0] idx);
      logic [W-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (SELW'(k) == idx) r = chan[k];
      end
      return r;
   endfunction

   // sel can exceed N-1 only when N is not a power of two
   assign sel_ok = (32'(bus.sel) < N);

   // Next-state and output selection; SCAN output follows the post-advance channel so
   // every channel (including the first after entry) is shown exactly DWELL cycles.
   always_comb begin
      state_d  = state_q;
      ch_d     = ch_q;
      dwell_d  = dwell_q;
      out_d    = '0;
      out_ch_d = '0;
      valid_d  = 1'b0;
      wrap_d   = 1'b0;

      unique case (state_q)
         ST_MANUAL: begin
            ch_d    = '0;
            dwell_d = '0;
            if (bus.mode) begin
               state_d = ST_SCAN;
               out_d   = chan[0];
               valid_d = 1'b1;
            end else if (sel_ok) begin
               out_d    = pick(bus.sel);
               out_ch_d = bus.sel;
               valid_d  = 1'b1;
            end
         end

         ST_SCAN: begin
            if (!bus.mode) begin
               state_d = ST_MANUAL;
               ch_d    = '0;
               dwell_d = '0;
               if (sel_ok) begin
                  out_d    = pick(bus.sel);
                  out_ch_d = bus.sel;
                  valid_d  = 1'b1;
               end
            end else begin
               if (!bus.hold) begin
                  if (dwell_q != DWELL_LAST) begin
                     dwell_d = dwell_q + 8'd1;
                  end else begin
                     dwell_d = '0;
                     ch_d    = (ch_q == LAST_CH) ? '0 : ch_q + SELW'(1);
                     wrap_d  = (ch_q == LAST_CH);
                  end
               end
               out_d    = pick(ch_d);
               out_ch_d = ch_d;
               valid_d  = 1'b1;
            end
         end

         default: state_d = ST_MANUAL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_MANUAL;
         ch_q     <= '0;
         dwell_q  <= '0;
         out_q    <= '0;
         out_ch_q <= '0;
         valid_q  <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         dwell_q  <= dwell_d;
         out_q    <= out_d;
         out_ch_q <= out_ch_d;
         valid_q  <= valid_d;
         wrap_q   <= wrap_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_ch    = out_ch_q;
   assign bus.out_valid = valid_q;
   assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_mux_nx1_scan.sv
// Scoreboard bench for mux_nx1_scan: a N=4/DWELL=3 instance and a N=5/DWELL=2 instance.
module tb_mux_nx1_scan;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   typedef struct packed {
      logic [7:0] out;
      logic [2:0] ch;
      logic       valid;
      logic       wrap;
   } exp_t;

   exp_t sb_q[$];

   mux_nx1_scan_if #(.N(4), .W(8)) ifa ();
   mux_nx1_scan_if #(.N(5), .W(8)) ifb ();

   mux_nx1_scan #(.N(4), .W(8), .DWELL(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   mux_nx1_scan #(.N(5), .W(8), .DWELL(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   always #5 clk = ~clk;

   // Channel c carries 0x11*(c+1) on both instances
   function automatic logic [7:0] dat(input int c);
      return 8'((c + 1) * 17);
   endfunction

   function automatic exp_t mk(input logic [7:0] o, input int c, input logic v, input logic w);
      exp_t e;
      e.out   = o;
      e.ch    = 3'(c);
      e.valid = v;
      e.wrap  = w;
      return e;
   endfunction

   function automatic exp_t obs_a();
      return {ifa.out, 1'b0, ifa.out_ch, ifa.out_valid, ifa.wrap};
   endfunction

   function automatic exp_t obs_b();
      return {ifb.out, ifb.out_ch, ifb.out_valid, ifb.wrap};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t zero;
      zero = '0;
      #2;
      n_checks++;
      if (obs_a() !== zero) begin
         n_errors++;
         $display("FAIL reset_a: got %h expected %h", obs_a(), zero);
      end
      n_checks++;
      if (obs_b() !== zero) begin
         n_errors++;
         $display("FAIL reset_b: got %h expected %h", obs_b(), zero);
      end
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_manual();
      int   sels [4] = '{2, 0, 3, 1};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         ifa.mode = 1'b0;
         ifa.sel  = 2'(sels[i]);
         sb_q.push_back(mk(dat(sels[i]), sels[i], 1'b1, 1'b0));
         tick();
         e = sb_q.pop_front();
         n_checks++;
         if (obs_a() !== e) begin
            n_errors++;
            $display("FAIL manual step %0d: got %h expected %h", i, obs_a(), e);
         end
      end
   endtask

   task automatic test_scan_seq();
      int   chs [14] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0};
      exp_t e;
      ifa.mode = 1'b1;
      ifa.hold = 1'b0;
      for (int i = 0; i < 14; i++) begin
         sb_q.push_back(mk(dat(chs[i]), chs[i], 1'b1, (i == 12)));
         tick();
         e = sb_q.pop_front();
         n_checks++;
         if (obs_a() !== e) begin
            n_errors++;
            $display("FAIL scan_seq step %0d: got %h expected %h", i, obs_a(), e);
         end
      end
      ifa.mode = 1'b0;
      ifa.sel  = 2'd1;
      sb_q.push_back(mk(dat(1), 1, 1'b1, 1'b0));
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (obs_a() !== e) begin
         n_errors++;
         $display("FAIL scan_exit: got %h expected %h", obs_a(), e);
      end
   endtask

   task automatic test_sel_oob();
      int   sels [5] = '{6, 5, 4, 7, 0};
      exp_t e;
      ifb.mode = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ifb.sel = 3'(sels[i]);
         if (sels[i] < 5) sb_q.push_back(mk(dat(sels[i]), sels[i], 1'b1, 1'b0));
         else             sb_q.push_back(mk(8'h00, 0, 1'b0, 1'b0));
         tick();
         e = sb_q.pop_front();
         n_checks++;
         if (obs_b() !== e) begin
            n_errors++;
            $display("FAIL sel_oob sel=%0d: got %h expected %h", sels[i], obs_b(), e);
         end
      end
   endtask

   task automatic test_hold();
      int   holds [18] = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      int   chs   [18] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0, 1};
      exp_t e;
      ifb.mode = 1'b1;
      for (int i = 0; i < 18; i++) begin
         ifb.hold = 1'(holds[i]);
         sb_q.push_back(mk(dat(chs[i]), chs[i], 1'b1, (i == 15)));
         tick();
         e = sb_q.pop_front();
         n_checks++;
         if (obs_b() !== e) begin
            n_errors++;
            $display("FAIL hold step %0d: got %h expected %h", i, obs_b(), e);
         end
      end
      ifb.hold = 1'b0;
      ifb.mode = 1'b0;
      ifb.sel  = 3'd7;
   endtask

   task automatic test_restart();
      int   modes [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
      int   chs   [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 0, 0, 0, 1};
      exp_t e;
      ifa.sel = 2'd3;
      for (int i = 0; i < 13; i++) begin
         ifa.mode = 1'(modes[i]);
         sb_q.push_back(mk(dat(chs[i]), chs[i], 1'b1, 1'b0));
         tick();
         e = sb_q.pop_front();
         n_checks++;
         if (obs_a() !== e) begin
            n_errors++;
            $display("FAIL restart step %0d: got %h expected %h", i, obs_a(), e);
         end
      end
   endtask

   task automatic test_async_reset();
      int   chs [4] = '{0, 0, 0, 1};
      exp_t e;
      exp_t zero;
      zero = '0;
      ifa.mode = 1'b0;
      tick();
      ifa.mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(mk(dat(chs[i]), chs[i], 1'b1, 1'b0));
         tick();
         e = sb_q.pop_front();
         n_checks++;
         if (obs_a() !== e) begin
            n_errors++;
            $display("FAIL pre_reset step %0d: got %h expected %h", i, obs_a(), e);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (obs_a() !== zero) begin
         n_errors++;
         $display("FAIL async_reset: got %h expected %h", obs_a(), zero);
      end
      #2;
      rst_n    = 1'b1;
      ifa.mode = 1'b0;
      ifa.sel  = 2'd2;
      sb_q.push_back(mk(dat(2), 2, 1'b1, 1'b0));
      tick();
      e = sb_q.pop_front();
      n_checks++;
      if (obs_a() !== e) begin
         n_errors++;
         $display("FAIL post_reset_manual: got %h expected %h", obs_a(), e);
      end
   endtask

   initial begin
      clk        = 1'b0;
      rst_n      = 1'b0;
      n_checks   = 0;
      n_errors   = 0;
      ifa.in_bus = {8'h44, 8'h33, 8'h22, 8'h11};
      ifa.mode   = 1'b0;
      ifa.sel    = 2'd0;
      ifa.hold   = 1'b0;
      ifb.in_bus = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      ifb.mode   = 1'b0;
      ifb.sel    = 3'd7;
      ifb.hold   = 1'b0;

      test_reset();
      test_manual();
      test_scan_seq();
      test_sel_oob();
      test_hold();
      test_restart();
      test_async_reset();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
